// File: rtl/regfile_pkg.sv
// Shared types and default geometry for the multi-port ARM32 register file.
// The PC select encoding is shared with the fetch/branch logic that drives pc_sel.
package regfile_pkg;

   typedef enum logic [1:0] {
      PC_INC   = 2'b00,
      PC_START = 2'b01,
      PC_TGT   = 2'b11
   } pc_sel_e;

   localparam int DEF_DATA_W = 32;
   localparam int DEF_NREGS  = 16;
   localparam int DEF_N_RD   = 4;
   localparam int DEF_N_WR   = 3;
   localparam int DEF_PC_W   = 11;
   localparam int DEF_PC_IDX = 15;

endpackage

// File: rtl/regfile_scoreboard.sv
// Per-register busy bits: a producer issue claims a register, any enabled
// write to it releases the claim. The PC register is never tracked.
module regfile_scoreboard
   import regfile_pkg::*;
#(
   parameter int NREGS  = DEF_NREGS,
   parameter int N_WR   = DEF_N_WR,
   parameter int PC_IDX = DEF_PC_IDX,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [N_WR-1:0]      wr_en,
   input  logic [N_WR*AW-1:0]   wr_addr,
   input  logic                 sb_set,
   input  logic [AW-1:0]        sb_set_addr,
   output logic [NREGS-1:0]     sb_busy
);

   logic [NREGS-1:0] busy_q;
   logic [NREGS-1:0] busy_nxt;

   // Clears are applied first so a same-cycle claim of the same register wins.
   always_comb begin
      busy_nxt = busy_q;
      for (int w = 0; w < N_WR; w++) begin
         if (wr_en[w]) begin
            busy_nxt[wr_addr[w*AW +: AW]] = 1'b0;
         end
      end
      if (sb_set) begin
         busy_nxt[sb_set_addr] = 1'b1;
      end
      busy_nxt[PC_IDX] = 1'b0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         busy_q <= '0;
      end else begin
         busy_q <= busy_nxt;
      end
   end

   assign sb_busy = busy_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-port GPR file: N_RD combinational reads with optional write bypass,
// N_WR prioritised writes, PC register update logic and a busy scoreboard.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int NREGS  = DEF_NREGS,
   parameter int N_RD   = DEF_N_RD,
   parameter int N_WR   = DEF_N_WR,
   parameter int PC_W   = DEF_PC_W,
   parameter int PC_IDX = DEF_PC_IDX,
   parameter int BYPASS = 1,
   localparam int AW    = $clog2(NREGS)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [N_WR-1:0]          wr_en,
   input  logic [N_WR*AW-1:0]       wr_addr,
   input  logic [N_WR*DATA_W-1:0]   wr_data,
   input  logic [N_RD*AW-1:0]       rd_addr,
   output logic [N_RD*DATA_W-1:0]   rd_data,
   input  logic                     pc_load,
   input  logic [1:0]               pc_sel,
   input  logic [PC_W-1:0]          pc_start,
   input  logic [PC_W-1:0]          pc_target,
   output logic [PC_W-1:0]          pc_out,
   input  logic                     sb_set,
   input  logic [AW-1:0]            sb_set_addr,
   output logic [NREGS-1:0]         sb_busy,
   input  logic [AW-1:0]            dbg_addr,
   output logic [DATA_W-1:0]        dbg_data
);

   logic [DATA_W-1:0] regs     [NREGS];
   logic [DATA_W-1:0] regs_nxt [NREGS];
   logic [PC_W-1:0]   pc_cur;
   logic [PC_W-1:0]   pc_next;
   logic [DATA_W-1:0] pc_ext;

   assign pc_cur = regs[PC_IDX][PC_W-1:0];

   always_comb begin
      pc_next = pc_cur + 1'b1;
      if (pc_sel == PC_START) begin
         pc_next = pc_start;
      end else if (pc_sel == PC_TGT) begin
         pc_next = pc_target;
      end
   end

   always_comb begin
      pc_ext             = '0;
      pc_ext[PC_W-1:0]   = pc_next;
   end

   // Ascending port order makes the highest-indexed enabled port the winner;
   // a PC load is applied last so it overrides any data write to PC_IDX.
   always_comb begin
      regs_nxt = regs;
      for (int w = 0; w < N_WR; w++) begin
         if (wr_en[w]) begin
            regs_nxt[wr_addr[w*AW +: AW]] = wr_data[w*DATA_W +: DATA_W];
         end
      end
      if (pc_load) begin
         regs_nxt[PC_IDX] = pc_ext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NREGS; i++) begin
            regs[i] <= '0;
         end
      end else begin
         regs <= regs_nxt;
      end
   end

   // Bypass forwards data-port writes only; the PC-load result is not visible
   // until the following cycle.
   for (genvar r = 0; r < N_RD; r++) begin : g_rd
      logic [AW-1:0]     ra;
      logic [DATA_W-1:0] rd_word;

      assign ra = rd_addr[r*AW +: AW];

      always_comb begin
         rd_word = regs[ra];
         if (BYPASS != 0) begin
            for (int w = 0; w < N_WR; w++) begin
               if (wr_en[w] && (wr_addr[w*AW +: AW] == ra)) begin
                  rd_word = wr_data[w*DATA_W +: DATA_W];
               end
            end
         end
      end

      assign rd_data[r*DATA_W +: DATA_W] = rd_word;
   end

   assign dbg_data = regs[dbg_addr];
   assign pc_out   = pc_cur;

   regfile_scoreboard #(
      .NREGS  (NREGS),
      .N_WR   (N_WR),
      .PC_IDX (PC_IDX)
   ) u_scoreboard (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .sb_busy     (sb_busy)
   );

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default-geometry instance with bypass
// plus a 64-bit/32-register instance without bypass.
module tb_regfile_mp;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   // ---------------- default instance (BYPASS=1) ----------------
   logic [2:0]   wr_en;
   logic [11:0]  wr_addr;
   logic [95:0]  wr_data;
   logic [15:0]  rd_addr;
   logic [127:0] rd_data;
   logic         pc_load;
   logic [1:0]   pc_sel;
   logic [10:0]  pc_start;
   logic [10:0]  pc_target;
   logic [10:0]  pc_out;
   logic         sb_set;
   logic [3:0]   sb_set_addr;
   logic [15:0]  sb_busy;
   logic [3:0]   dbg_addr;
   logic [31:0]  dbg_data;

   regfile_mp u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .rd_data     (rd_data),
      .pc_load     (pc_load),
      .pc_sel      (pc_sel),
      .pc_start    (pc_start),
      .pc_target   (pc_target),
      .pc_out      (pc_out),
      .sb_set      (sb_set),
      .sb_set_addr (sb_set_addr),
      .sb_busy     (sb_busy),
      .dbg_addr    (dbg_addr),
      .dbg_data    (dbg_data)
   );

   // ---------------- wide instance (BYPASS=0) ----------------
   logic [0:0]   w64_en;
   logic [4:0]   w64_addr;
   logic [63:0]  w64_data;
   logic [9:0]   rd64_addr;
   logic [127:0] rd64_data;
   logic [10:0]  pc64_out;
   logic [31:0]  busy64;
   logic [4:0]   dbg64_addr;
   logic [63:0]  dbg64_data;

   regfile_mp #(
      .DATA_W (64),
      .NREGS  (32),
      .N_RD   (2),
      .N_WR   (1),
      .PC_W   (11),
      .PC_IDX (31),
      .BYPASS (0)
   ) u_dut64 (
      .clk         (clk),
      .rst_n       (rst_n),
      .wr_en       (w64_en),
      .wr_addr     (w64_addr),
      .wr_data     (w64_data),
      .rd_addr     (rd64_addr),
      .rd_data     (rd64_data),
      .pc_load     (1'b0),
      .pc_sel      (2'b00),
      .pc_start    (11'd0),
      .pc_target   (11'd0),
      .pc_out      (pc64_out),
      .sb_set      (1'b0),
      .sb_set_addr (5'd0),
      .sb_busy     (busy64),
      .dbg_addr    (dbg64_addr),
      .dbg_data    (dbg64_data)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_errors = 0;
   logic [63:0] exp_q[$];

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_regs [16];
   logic [15:0] m_busy;

   task automatic m_reset();
      for (int i = 0; i < 16; i++) m_regs[i] = 32'h0;
      m_busy = 16'h0;
   endtask

   function automatic logic [31:0] m_read(input logic [3:0] a);
      logic [31:0] v;
      v = m_regs[a];
      for (int w = 0; w < 3; w++)
         if (wr_en[w] && wr_addr[w*4 +: 4] == a) v = wr_data[w*32 +: 32];
      return v;
   endfunction

   task automatic m_update();
      logic [31:0] nr [16];
      logic [15:0] nb;
      logic [10:0] pc;
      nr = m_regs;
      nb = m_busy;
      for (int w = 0; w < 3; w++) begin
         if (wr_en[w]) begin
            nr[wr_addr[w*4 +: 4]] = wr_data[w*32 +: 32];
            nb[wr_addr[w*4 +: 4]] = 1'b0;
         end
      end
      if (sb_set && sb_set_addr != 4'd15) nb[sb_set_addr] = 1'b1;
      if (pc_load) begin
         pc = m_regs[15][10:0];
         if (pc_sel == 2'b01)      pc = pc_start;
         else if (pc_sel == 2'b11) pc = pc_target;
         else                      pc = pc + 11'd1;
         nr[15] = {21'd0, pc};
      end
      m_regs = nr;
      m_busy = nb;
   endtask

   // ---------------- driver tasks ----------------
   task automatic drive_idle();
      wr_en = '0; wr_addr = '0; wr_data = '0; rd_addr = '0;
      pc_load = 1'b0; pc_sel = 2'b00; pc_start = '0; pc_target = '0;
      sb_set = 1'b0; sb_set_addr = '0; dbg_addr = '0;
      w64_en = '0; w64_addr = '0; w64_data = '0; rd64_addr = '0; dbg64_addr = '0;
   endtask

   task automatic drive_wr(input int port, input logic [3:0] a, input logic [31:0] d);
      wr_en[port] = 1'b1;
      wr_addr[port*4 +: 4] = a;
      wr_data[port*32 +: 32] = d;
   endtask

   // Inputs are set just after a negedge; reads checked before the posedge,
   // registered state checked #1 after it; returns at the next negedge.
   task automatic tick();
      #1;
      for (int r = 0; r < 4; r++) exp_q.push_back({32'd0, m_read(rd_addr[r*4 +: 4])});
      for (int r = 0; r < 4; r++) check($sformatf("rd%0d", r), {32'd0, rd_data[r*32 +: 32]}, exp_q.pop_front());
      @(posedge clk);
      m_update();
      #1;
      exp_q.push_back({53'd0, m_regs[15][10:0]});
      exp_q.push_back({48'd0, m_busy});
      exp_q.push_back({32'd0, m_regs[dbg_addr]});
      check("pc_out", {53'd0, pc_out}, exp_q.pop_front());
      check("sb_busy", {48'd0, sb_busy}, exp_q.pop_front());
      check("dbg", {32'd0, dbg_data}, exp_q.pop_front());
      @(negedge clk);
   endtask

   function automatic logic [3:0] rand_addr();
      return ($urandom_range(0, 1) == 0) ? 4'($urandom_range(4, 7)) : 4'($urandom_range(0, 15));
   endfunction

   // ---------------- main sequence ----------------
   initial begin
      drive_idle();
      m_reset();
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      check("reset_pc", {53'd0, pc_out}, 64'h0);
      check("reset_busy", {48'd0, sb_busy}, 64'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // make state non-zero, then reset in the middle of a write
      drive_wr(0, 4'd3, 32'h0000_1234);
      sb_set = 1'b1; sb_set_addr = 4'd4;
      pc_load = 1'b1; pc_sel = 2'b01; pc_start = 11'h055;
      tick();
      drive_idle();
      drive_wr(0, 4'd3, 32'hDEAD_BEEF);
      dbg_addr = 4'd3;
      #2;
      rst_n = 1'b0;
      m_reset();
      @(posedge clk);
      #1;
      check("rst_r3", {32'd0, dbg_data}, 64'h0);
      check("rst_pc", {53'd0, pc_out}, 64'h0);
      check("rst_busy", {48'd0, sb_busy}, 64'h0);
      @(negedge clk);
      drive_idle();
      rst_n = 1'b1;
      @(negedge clk);

      // write conflict on r5
      drive_wr(0, 4'd5, 32'h0000_0077);
      tick();
      drive_idle();
      drive_wr(0, 4'd5, 32'h11); drive_wr(1, 4'd5, 32'h22); drive_wr(2, 4'd5, 32'h33);
      rd_addr[3:0] = 4'd5;
      dbg_addr = 4'd5;
      #1;
      check("conflict_bypass", {32'd0, rd_data[31:0]}, 64'h33);
      tick();
      check("conflict_r5", {32'd0, dbg_data}, 64'h33);

      // PC sequencing
      drive_idle();
      dbg_addr = 4'd15;
      pc_load = 1'b1; pc_sel = 2'b01; pc_start = 11'h100;
      tick();
      check("pc_start", {53'd0, pc_out}, 64'h100);
      pc_sel = 2'b00;
      tick(); pc_sel = 2'b10; tick(); pc_sel = 2'b00; tick();
      check("pc_inc3", {53'd0, pc_out}, 64'h103);
      pc_sel = 2'b01; pc_start = 11'h7FF;
      tick();
      pc_sel = 2'b00;
      tick();
      check("pc_wrap", {53'd0, pc_out}, 64'h000);
      pc_sel = 2'b11; pc_target = 11'h2A0;
      drive_wr(0, 4'd15, 32'h555);
      tick();
      check("pc_tgt_over", {53'd0, pc_out}, 64'h2A0);
      check("pc_tgt_r15", {32'd0, dbg_data}, 64'h2A0);

      // PC written through a data port
      drive_idle();
      dbg_addr = 4'd15;
      drive_wr(1, 4'd15, 32'hFFFF_F123);
      tick();
      check("pc_data", {53'd0, pc_out}, 64'h123);
      check("pc_data_r15", {32'd0, dbg_data}, 64'hFFFF_F123);

      // scoreboard
      drive_idle();
      sb_set = 1'b1; sb_set_addr = 4'd4;
      tick();
      check("sb_set4", {63'd0, sb_busy[4]}, 64'h1);
      drive_wr(2, 4'd4, 32'hABCD);
      tick();
      check("sb_setclr4", {63'd0, sb_busy[4]}, 64'h1);
      sb_set = 1'b0;
      tick();
      check("sb_clr4", {63'd0, sb_busy[4]}, 64'h0);
      drive_idle();
      sb_set = 1'b1; sb_set_addr = 4'd15;
      tick();
      check("sb_pc", {63'd0, sb_busy[15]}, 64'h0);

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         drive_idle();
         for (int w = 0; w < 3; w++)
            if ($urandom_range(0, 2) != 0) drive_wr(w, rand_addr(), $urandom());
         for (int r = 0; r < 4; r++) rd_addr[r*4 +: 4] = rand_addr();
         pc_load = ($urandom_range(0, 3) == 0);
         pc_sel = 2'($urandom_range(0, 3));
         pc_start = 11'($urandom());
         pc_target = 11'($urandom());
         sb_set = ($urandom_range(0, 1) == 1);
         sb_set_addr = rand_addr();
         dbg_addr = 4'($urandom_range(0, 15));
         tick();
      end

      // wide instance without bypass
      drive_idle();
      w64_en = 1'b1; w64_addr = 5'd31; w64_data = 64'h0123_4567_89AB_CDEF;
      rd64_addr = {5'd31, 5'd31};
      dbg64_addr = 5'd31;
      #1;
      check("w64_nobypass", rd64_data[63:0], 64'h0);
      @(posedge clk); #1;
      check("w64_dbg31", dbg64_data, 64'h0123_4567_89AB_CDEF);
      check("w64_rd31", rd64_data[127:64], 64'h0123_4567_89AB_CDEF);
      check("w64_pc", {53'd0, pc64_out}, 64'h5EF);
      @(negedge clk);
      w64_addr = 5'd5; w64_data = 64'h33;
      rd64_addr = {5'd5, 5'd5};
      #1;
      check("w64_old_r5", rd64_data[63:0], 64'h0);
      @(posedge clk); #1;
      check("w64_new_r5", rd64_data[127:64], 64'h33);
      @(negedge clk);
      drive_idle();

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
